// File: rtl/mdu_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module : mdu_scheduler_pkg
// Brief  : Shared MDU definitions: op encoding, scheduler states, op helpers.
// Rev    : 1.0  initial release
// ============================================================================
package mdu_scheduler_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MADD  = 3'd4,
        MDU_MADDU = 3'd5,
        MDU_MSUB  = 3'd6,
        MDU_MSUBU = 3'd7
    } MduOp_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_ACC  = 3'd2,
        ST_DIV  = 3'd3,
        ST_FIX  = 3'd4,
        ST_DONE = 3'd5
    } mdu_state_t;

    localparam int DIV_CNT_W = 6;

    function automatic logic op_is_div(input MduOp_t op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic op_is_signed(input MduOp_t op);
        return (op == MDU_MULT) || (op == MDU_DIV) || (op == MDU_MADD) || (op == MDU_MSUB);
    endfunction

    function automatic logic op_is_acc(input MduOp_t op);
        return (op == MDU_MADD) || (op == MDU_MADDU) || (op == MDU_MSUB) || (op == MDU_MSUBU);
    endfunction

    function automatic logic op_is_sub(input MduOp_t op);
        return (op == MDU_MSUB) || (op == MDU_MSUBU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_scheduler_div.sv
`default_nettype none
// ============================================================================
// Module : div_iter
// Brief  : Radix-2 restoring divider on unsigned magnitudes, one bit per cycle.
// Rev    : 1.0  initial release
// ============================================================================
module div_iter
    import mdu_scheduler_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic        o_done,
    output logic [31:0] o_quo,
    output logic [31:0] o_rem
);

    logic                 r_run;
    logic [DIV_CNT_W-1:0] r_cnt;
    logic [31:0]          r_quo;
    logic [31:0]          r_rem;
    logic [31:0]          r_dvs;

    logic [32:0]          w_shift;
    logic [33:0]          w_diff;
    logic                 w_ge;

    // Extra guard bit keeps the compare honest when the shifted remainder uses bit 32.
    assign w_shift = {r_rem, r_quo[31]};
    assign w_diff  = {1'b0, w_shift} - {2'b00, r_dvs};
    assign w_ge    = ~w_diff[33];

    // Asserted during the cycle whose closing edge performs the final iteration.
    assign o_done = r_run && (r_cnt == DIV_CNT_W'(DIV_CYCLES - 1));
    assign o_quo  = r_quo;
    assign o_rem  = r_rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run <= 1'b0;
            r_cnt <= '0;
            r_quo <= '0;
            r_rem <= '0;
            r_dvs <= '0;
        end else if (i_abort) begin
            r_run <= 1'b0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_run <= 1'b1;
            r_cnt <= '0;
            r_quo <= i_dividend;
            r_rem <= '0;
            r_dvs <= i_divisor;
        end else if (r_run) begin
            r_rem <= w_ge ? w_diff[31:0] : w_shift[31:0];
            r_quo <= {r_quo[30:0], w_ge};
            r_cnt <= r_cnt + 1'b1;
            if (o_done) begin
                r_run <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mdu_scheduler.sv
`default_nettype none
// ============================================================================
// Module : mdu_scheduler
// Brief  : Multi-cycle multiply/divide/accumulate scheduler writing HI/LO.
// Rev    : 1.0  initial release
// ============================================================================
module mdu_scheduler
    import mdu_scheduler_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    input  logic [31:0] hi_in,
    input  logic [31:0] lo_in,
    output logic        mdu_stall,
    output logic        hilo_we,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        busy
);

    mdu_state_t  r_state;
    mdu_state_t  w_state_nxt;
    MduOp_t      r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [63:0] r_prod;
    logic [63:0] r_res;
    logic [31:0] r_hi_hold;
    logic [31:0] r_lo_hold;

    MduOp_t      w_op_in;
    logic        w_accept;
    logic        w_in_sgn;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic        w_div_done;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic        w_sgn;
    logic [63:0] w_ma;
    logic [63:0] w_mb;
    logic [63:0] w_prod;
    logic        w_neg_q;
    logic        w_neg_r;
    logic [31:0] w_fix_quo;
    logic [31:0] w_fix_rem;

    assign w_op_in  = MduOp_t'(op);
    assign w_accept = (r_state == ST_IDLE) && op_valid && !flush;

    // Divider is loaded straight from the ports on the accept edge.
    assign w_in_sgn = op_is_signed(w_op_in);
    assign w_mag_a  = (w_in_sgn && src_a[31]) ? -src_a : src_a;
    assign w_mag_b  = (w_in_sgn && src_b[31]) ? -src_b : src_b;

    div_iter #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div_iter (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_accept && op_is_div(w_op_in)),
        .i_abort    (flush),
        .i_dividend (w_mag_a),
        .i_divisor  (w_mag_b),
        .o_done     (w_div_done),
        .o_quo      (w_quo),
        .o_rem      (w_rem)
    );

    // Low 64 bits of the extended product are the correct signed or unsigned result.
    assign w_sgn  = op_is_signed(r_op);
    assign w_ma   = w_sgn ? {{32{r_a[31]}}, r_a} : {32'd0, r_a};
    assign w_mb   = w_sgn ? {{32{r_b[31]}}, r_b} : {32'd0, r_b};
    assign w_prod = w_ma * w_mb;

    assign w_neg_q   = w_sgn && (r_a[31] ^ r_b[31]);
    assign w_neg_r   = w_sgn && r_a[31];
    assign w_fix_quo = w_neg_q ? -w_quo : w_quo;
    assign w_fix_rem = w_neg_r ? -w_rem : w_rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        mdu_stall   = 1'b0;
        hilo_we     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                mdu_stall = w_accept;
                if (w_accept) begin
                    w_state_nxt = op_is_div(w_op_in) ? ST_DIV : ST_MUL;
                end
            end
            ST_MUL: begin
                mdu_stall   = 1'b1;
                w_state_nxt = op_is_acc(r_op) ? ST_ACC : ST_DONE;
            end
            ST_ACC: begin
                mdu_stall   = 1'b1;
                w_state_nxt = ST_DONE;
            end
            ST_DIV: begin
                mdu_stall = 1'b1;
                if (w_div_done) begin
                    w_state_nxt = ST_FIX;
                end
            end
            ST_FIX: begin
                mdu_stall   = 1'b1;
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                hilo_we     = !flush;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (flush) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op      <= MDU_MULT;
            r_a       <= '0;
            r_b       <= '0;
            r_prod    <= '0;
            r_res     <= '0;
            r_hi_hold <= '0;
            r_lo_hold <= '0;
        end else begin
            if (w_accept) begin
                r_op <= w_op_in;
                r_a  <= src_a;
                r_b  <= src_b;
            end
            case (r_state)
                ST_MUL: begin
                    r_prod <= w_prod;
                    r_res  <= w_prod;
                end
                ST_ACC: begin
                    r_res <= op_is_sub(r_op) ? ({hi_in, lo_in} - r_prod)
                                             : ({hi_in, lo_in} + r_prod);
                end
                ST_FIX: begin
                    r_res <= {w_fix_rem, w_fix_quo};
                end
                default: ;
            endcase
            if (hilo_we) begin
                r_hi_hold <= r_res[63:32];
                r_lo_hold <= r_res[31:0];
            end
        end
    end

    // Result is visible only on the strobe; otherwise the last written value holds.
    assign hi_out = hilo_we ? r_res[63:32] : r_hi_hold;
    assign lo_out = hilo_we ? r_res[31:0]  : r_lo_hold;
    assign busy   = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mdu_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_mdu_scheduler
// Brief  : Scoreboard bench for mdu_scheduler with directed and random ops.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mdu_scheduler;
    import mdu_scheduler_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        flush = 1'b0;
    logic [31:0] hi_in = '0;
    logic [31:0] lo_in = '0;
    logic        mdu_stall;
    logic        hilo_we;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [63:0] res;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          we_cyc[$];
    logic [63:0] hold_exp = '0;

    mdu_scheduler #(
        .DIV_CYCLES (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .op_valid  (op_valid),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .flush     (flush),
        .hi_in     (hi_in),
        .lo_in     (lo_in),
        .mdu_stall (mdu_stall),
        .hilo_we   (hilo_we),
        .hi_out    (hi_out),
        .lo_out    (lo_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference results from plain arithmetic on the architectural rules.
    function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] h,
                                              input logic [31:0] l);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        logic [31:0] q;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (o == MDU_MULT || o == MDU_MADD || o == MDU_MSUB) p = 64'(sa * sb);
        else p = {32'd0, a} * {32'd0, b};
        case (o)
            MDU_MULT, MDU_MULTU: return p;
            MDU_MADD, MDU_MADDU: return {h, l} + p;
            MDU_MSUB, MDU_MSUBU: return {h, l} - p;
            MDU_DIVU: begin
                if (b == 0) begin q = 32'hFFFF_FFFF; r = a; end
                else begin q = a / b; r = a % b; end
            end
            default: begin
                if (b == 0) begin
                    // magnitude quotient all-ones, remainder |a|, then sign fix-up
                    q = a[31] ? 32'd1 : 32'hFFFF_FFFF;
                    r = a;
                end else begin
                    q = 32'(sa / sb);
                    r = 32'(sa % sb);
                end
            end
        endcase
        return {r, q};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            hold_exp = '0;
            chk("rst_hilo", {hi_out, lo_out}, 64'd0);
            chk("rst_flags", {61'd0, hilo_we, busy, mdu_stall}, 64'd0);
        end else if (hilo_we) begin
            we_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("spurious_we", {63'd0, hilo_we}, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("result", {hi_out, lo_out}, mon_e.res);
                chk("latency", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
                hold_exp = mon_e.res;
            end
        end else begin
            chk("hold", {hi_out, lo_out}, hold_exp);
        end
    end

    // Issue one op at posedge+1 of an IDLE cycle; in-flight inputs are scrambled.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] h, input logic [31:0] l,
                         input logic use_c, input logic [63:0] cval);
        int   lat;
        int   stalls;
        exp_t e;
        stalls = 0;
        chk("idle_before_issue", {63'd0, busy}, 64'd0);
        if (o == MDU_DIV || o == MDU_DIVU) lat = 34;
        else if (o == MDU_MULT || o == MDU_MULTU) lat = 2;
        else lat = 3;
        op_valid = 1'b1; op = o; src_a = a; src_b = b; hi_in = h; lo_in = l;
        e.res = use_c ? cval : ref_model(o, a, b, h, l);
        e.acc = cyc;
        e.lat = lat;
        exp_q.push_back(e);
        for (int k = 0; k <= lat; k++) begin
            @(negedge clk);
            if (mdu_stall) stalls++;
            @(posedge clk);
            #1;
            if (k < lat) begin
                op_valid = 1'($urandom);
                op       = 3'($urandom);
                src_a    = $urandom;
                src_b    = $urandom;
            end else begin
                op_valid = 1'b0;
            end
        end
        chk("stall_cycles", 64'(stalls), 64'(lat));
    endtask

    // Flush lands in cycle 'at' counted from the accept cycle (0 = same cycle).
    task automatic issue_flush(input logic [2:0] o, input logic [31:0] a,
                               input logic [31:0] b, input int at);
        op_valid = 1'b1; op = o; src_a = a; src_b = b;
        for (int k = 0; k < at; k++) begin
            @(posedge clk);
            #1;
            op_valid = 1'b0;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        op_valid = 1'b0;
        chk("flush_busy", {63'd0, busy}, 64'd0);
        chk("flush_stall", {63'd0, mdu_stall}, 64'd0);
        chk("flush_we", {63'd0, hilo_we}, 64'd0);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom % 6)
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return $urandom % 16;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int n0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {61'd0, busy, hilo_we, mdu_stall}, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        issue(MDU_MULT,  32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA);
        issue(MDU_MADDU, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b1, 64'h0000_0001_0000_0000);
        issue(MDU_DIV,   32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD);
        issue(MDU_DIVU,  32'd7, 32'd0, 32'd0, 32'd0, 1'b1, 64'h0000_0007_FFFF_FFFF);
        issue(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b1, 64'h0000_0000_8000_0000);
        issue(MDU_DIV,   32'hFFFF_FFF9, 32'd0, 32'd0, 32'd0, 1'b1, 64'hFFFF_FFF9_0000_0001);
        issue(MDU_MSUB,  32'hFFFF_FFFD, 32'd5, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 64'd0);

        issue_flush(MDU_DIVU, 32'd100, 32'd3, 10);
        issue(MDU_MULTU, 32'd5, 32'd5, 32'd0, 32'd0, 1'b1, 64'd25);
        issue_flush(MDU_MULT, 32'd9, 32'd9, 2);
        issue_flush(MDU_MADD, 32'd9, 32'd9, 2);
        issue_flush(MDU_MULTU, 32'd9, 32'd9, 0);
        issue(MDU_DIVU, 32'd100, 32'd3, 32'd0, 32'd0, 1'b1, 64'h0000_0001_0000_0021);

        n0 = we_cyc.size();
        issue(MDU_MULT,  32'd6, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 64'd0);
        issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 64'd0);
        chk("b2b_pulses", 64'(we_cyc.size() - n0), 64'd2);
        if (we_cyc.size() - n0 == 2)
            chk("b2b_spacing", 64'(we_cyc[n0 + 1] - we_cyc[n0]), 64'd3);

        op_valid = 1'b1; op = MDU_MULTU; src_a = 32'd77; src_b = 32'd3;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_mid_outputs", {hi_out, lo_out}, 64'd0);
        chk("rst_mid_flags", {61'd0, busy, hilo_we, mdu_stall}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        for (int i = 0; i < 40; i++) begin
            issue(3'($urandom), rnd_operand(), rnd_operand(), $urandom, $urandom, 1'b0, 64'd0);
        end

        repeat (2) @(posedge clk);
        #1;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
